serial_sat_add_ctrl: RTL
========================

Name: serial_sat_add_ctrl

Overview:
Bit-serial signed adder with saturation, sequenced by a small controller. It accepts one pair of two's-complement operands over a valid/ready handshake and feeds them LSB-first through a single 1-bit full adder, one bit per clock. On the last bit it applies signed saturation and holds the result until the consumer accepts it. It is the area-cheap, multi-cycle counterpart of the combinational saturating adder, for datapaths that trade latency for gate count.

Parameters:
WIDTH, 4, operand/result width in bits, two's complement; legal range 2..32.

Ports:
clk        input   1      clock; all state updates on posedge
rst        input   1      synchronous reset, active-high
in_valid   input   1      operand pair a/b valid
in_ready   output  1      controller can accept an operand pair
a          input   WIDTH  signed operand A, sampled on in_valid & in_ready
b          input   WIDTH  signed operand B, sampled on in_valid & in_ready
out_valid  output  1      sum/flags valid
out_ready  input   1      consumer accepts result
sum        output  WIDTH  saturated signed sum
sat_pos    output  1      result clamped to max positive (2^(WIDTH-1)-1)
sat_neg    output  1      result clamped to min negative (-2^(WIDTH-1))

Behaviour:
- States: IDLE, RUN, DONE. Reset is the only path into IDLE except the normal DONE exit.
- Reset: rst high at a posedge puts the block in IDLE and clears carry, bit counter, shift registers, sum, sat_pos, sat_neg, and out_valid to 0. in_ready is 1 from the first cycle after reset.
- IDLE: in_ready=1 and out_valid=0. On in_valid & in_ready at edge T, the block latches a and b into shift registers, clears carry and the bit counter, and goes to RUN.
- RUN: in_ready=0 and out_valid=0. In each cycle it computes bit i as a_sh[0] ^ b_sh[0] ^ carry. The next carry is majority(a_sh[0], b_sh[0], carry). The result bit shifts into the result register from the MSB side. a_sh and b_sh shift right, and the counter increments. Bit i is processed in cycle T+1+i, for i = 0..WIDTH-1.
- On the edge ending bit WIDTH-1, the block goes to DONE and registers the saturation decision:
  - Overflow when sign(a) == sign(b) and sign(raw result) != sign(a). Sign is taken from the latched operand MSBs, not from the shifted registers.
  - Overflow with sign(a)=0: sum = 0111..1 and sat_pos=1.
  - Overflow with sign(a)=1: sum = 1000..0 and sat_neg=1.
  - Otherwise sum = raw result, and both flags are 0. sat_pos and sat_neg are never both 1.
  - The final carry-out is discarded. A wrap-around without overflow (e.g. -1 + -1) is a legal result.
- DONE: out_valid=1 and in_ready=0. sum and the flags are stable while out_valid=1 and out_ready=0, for any number of cycles.
- On out_valid & out_ready the block goes to IDLE. out_valid drops next cycle, while sum and the flags hold their last values. There is no same-cycle re-accept, because in_ready is 0 in DONE.
- Latency: with acceptance at edge T, out_valid is 1 in cycle T+WIDTH+1. Throughput is one operation per WIDTH+2 cycles with out_ready tied high.
- in_valid while not in IDLE is ignored, and a/b are not sampled.
- Operands are latched at acceptance, so a and b may change during RUN without effect.
- Reset mid-RUN or mid-DONE aborts the operation. No out_valid pulse is produced, and the result is lost.
- Reset has priority over every handshake in the same cycle.
- The counter is $clog2(WIDTH) bits wide (minimum 1) and never wraps past WIDTH-1.
- No combinational path from inputs to outputs. in_ready and out_valid are decoded from the state register only.

Test Plan:
1. WIDTH=4, a=3, b=2, out_ready=1 → out_valid in cycle T+5; sum=0101, sat_pos=0, sat_neg=0; in_ready returns to 1 in cycle T+6.
2. a=7, b=1 → sum=0111, sat_pos=1, sat_neg=0. Also a=5, b=6 → sum=0111, sat_pos=1.
3. a=-8 (1000), b=-1 (1111) → sum=1000, sat_neg=1. Also a=-3, b=-2 → sum=1011 (-5), no flag, carry-out ignored.
4. Mixed signs a=-8, b=7 → sum=1111 (-1), no flags. Also a=-3, b=2 → sum=1111, no flags.
5. Backpressure: out_ready=0 for 10 cycles after out_valid → sum and flags stable and in_ready=0 throughout; a new in_valid in that window is not taken; release out_ready → IDLE, then the pending pair is accepted.
6. Assert rst in the 2nd RUN cycle → next cycle IDLE, in_ready=1, out_valid=0, sum=0; a following 3+2 gives 0101 with normal latency. Also sweep all 256 pairs against a saturating reference model with random out_ready.

Source files
------------

// File: rtl/serial_sat_add_ctrl_if.sv
// Handshake bundle for the bit-serial saturating adder: operand request
// channel (a/b) and result channel (sum plus saturation flags).
interface serial_sat_add_ctrl_if #(
  parameter int WIDTH = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] sum;
  logic                    sat_pos;
  logic                    sat_neg;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, sat_pos, sat_neg
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, sat_pos, sat_neg
  );
endinterface

// File: rtl/serial_sat_add_ctrl.sv
// Bit-serial two's-complement adder with signed saturation: one full-adder
// bit per clock, LSB first, sequenced by an IDLE/RUN/DONE controller.
module serial_sat_add_ctrl #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  serial_sat_add_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Returns {sat_pos, sat_neg, sum}; overflow is judged from the operand signs
  // captured at acceptance, and the adder's final carry-out plays no part.
  function automatic logic [WIDTH+1:0] saturate(input logic [WIDTH-1:0] raw,
                                                input logic sign_a,
                                                input logic sign_b);
    logic [WIDTH-1:0] max_pos;
    logic [WIDTH-1:0] min_neg;
    logic             ovf;
    max_pos = {1'b0, {(WIDTH-1){1'b1}}};
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    ovf     = (sign_a == sign_b) && (raw[WIDTH-1] != sign_a);
    if (ovf && !sign_a)     saturate = {1'b1, 1'b0, max_pos};
    else if (ovf && sign_a) saturate = {1'b0, 1'b1, min_neg};
    else                    saturate = {1'b0, 1'b0, raw};
  endfunction

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        a_sh_q, a_sh_d;
  logic [WIDTH-1:0]        b_sh_q, b_sh_d;
  logic [WIDTH-2:0]        res_q, res_d;
  logic                    carry_q, carry_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sign_a_q, sign_a_d;
  logic                    sign_b_q, sign_b_d;
  logic signed [WIDTH-1:0] sum_q, sum_d;
  logic                    sat_pos_q, sat_pos_d;
  logic                    sat_neg_q, sat_neg_d;

  logic                    bit_s;
  logic [WIDTH-1:0]        raw_s;

  // res_q holds the bits already produced; the current bit completes the word.
  assign bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign raw_s = {bit_s, res_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      sum_q     <= '0;
      sat_pos_q <= 1'b0;
      sat_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      sum_q     <= sum_d;
      sat_pos_q <= sat_pos_d;
      sat_neg_q <= sat_neg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    sum_d     = sum_q;
    sat_pos_d = sat_pos_q;
    sat_neg_d = sat_neg_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          sign_a_d = bus.a[WIDTH-1];
          sign_b_d = bus.b[WIDTH-1];
          res_d    = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        carry_d = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        res_d   = raw_s[WIDTH-1:1];
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        if (cnt_q == LAST_BIT) begin
          {sat_pos_d, sat_neg_d, sum_d} = saturate(raw_s, sign_a_q, sign_b_q);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.sat_pos   = sat_pos_q;
  assign bus.sat_neg   = sat_neg_q;

endmodule
